decay_timer: RTL and testbench
==============================

# decay_timer

Measures the muon lifetime: the interval between a start pulse (muon arrival, channel A) and a stop pulse (decay electron, channel B). Inputs are single-cycle, already-debounced pulses from the core logic. It counts elapsed time in 4-digit BCD and latches the last accepted interval and a BCD count of accepted decays. Both outputs are 16-bit BCD words that feed the multiplexed display alongside `digits_A`/`digits_B`/`digits_C`.

## Interface
- `TICK_DIV`, 100: clock cycles per time tick (1 µs at 100 MHz); must be ≥ 2.
- `MIN_TICKS`, 2: minimum accepted interval in ticks; used only when `DECAY_MIN_FILTER_EN` is defined.
- `clk` input 1: 100 MHz system clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_pulse` input 1: one-cycle pulse, channel A event.
- `stop_pulse` input 1: one-cycle pulse, channel B event.
- `digits_T` output 16: BCD of the last accepted interval in ticks, nibble [15:12] most significant; reset 16'h0000.
- `digits_N` output 16: BCD count of accepted decays, saturates at 9999; reset 16'h0000.
- `busy` output 1: high while timing; reset 0.
- `done` output 1: one-cycle pulse when `digits_T` updates; reset 0.
- `timeout` output 1: one-cycle pulse on an overflow abort; reset 0.

## Operation
- FSM states: IDLE, TIMING.
- **IDLE**
  - `start_pulse` clears the prescaler and the elapsed BCD counter, then enters TIMING.
  - `stop_pulse` is ignored.
- **TIMING**
  - The prescaler counts 0..TICK_DIV-1. The elapsed counter increments by one BCD step each time the prescaler wraps.
  - `stop_pulse`: load elapsed into `digits_T`, increment `digits_N`, pulse `done`, go to IDLE.
  - `start_pulse` without a stop (retrigger): clear the prescaler and elapsed counter, stay in TIMING. Outputs are unchanged.
  - `stop_pulse` and `start_pulse` in the same cycle: the stop is processed, the start is dropped, and the FSM goes to IDLE.
  - Overflow: elapsed = 9999 with a tick due. Pulse `timeout` and go to IDLE. `digits_T` and `digits_N` are unchanged.
- BCD arithmetic:
  - Each digit wraps 9→0 and carries into the next digit.
  - Nibble values A–F never occur.
  - No binary-to-BCD conversion is used.
- `digits_N` at 9999 holds at 9999. `done` still pulses.
- Asynchronous reset at any time, including mid-measurement:
  - FSM returns to IDLE.
  - All counters clear.
  - All outputs take their reset values.
  - No `done` or `timeout` pulse is produced.

## Timing
- Define start accepted at edge n and stop sampled at edge m.
- Captured value = floor((m − n − 1) / TICK_DIV) ticks, saturating below the overflow limit.
- `busy` rises at edge n+1 and falls at edge m+1.
- `digits_T` and `digits_N` update at edge m+1. `done` is high for exactly the cycle after edge m+1.
- `timeout` is high for one cycle, the cycle after the overflow edge.
- A `start_pulse` on the cycle right after a stop/timeout is accepted normally (zero dead time).
- Inputs are synchronous to `clk`. No synchronisers are inside this block.

## Configuration
- Macro: `DECAY_MIN_FILTER_EN`.
- **Defined:** in TIMING, a `stop_pulse` with elapsed < `MIN_TICKS` is ignored and timing continues (afterpulse rejection). No `done` pulse and no counter change.
- **Undefined:** every stop in TIMING is accepted. `MIN_TICKS` is unused.

## Structure
- Package `decay_pkg` holds:
  - the state enum type (IDLE, TIMING);
  - a 4-bit BCD digit typedef and a 16-bit BCD word typedef;
  - the constant `BCD_MAX` = 16'h9999.
- Sub-module `bcd_counter4`: 4-digit BCD counter.
  - Inputs: synchronous clear and increment enable.
  - Outputs: value and an `at_max` flag.
  - Instanced twice: once for elapsed time, once for the event count.

## Test plan
- **Basic measurement:** reset, then start, then stop 250 cycles later (TICK_DIV=100).
  - `digits_T`=16'h0002, `digits_N`=16'h0001.
  - `done` pulses once; `busy` is high for 250 cycles.
- **Stop without start:** `stop_pulse` in IDLE → no `done`, outputs stay 16'h0000.
- **Retrigger:** start, 500 cycles, start again, stop after 1234 more cycles (TICK_DIV=10).
  - `digits_T`=16'h0123, `digits_N`=16'h0001.
- **Overflow:** TICK_DIV=2, start, no stop.
  - `timeout` pulses after 20000 cycles; `busy` drops.
  - `digits_T`/`digits_N` keep their prior values.
- **Simultaneous start and stop while TIMING:** the stop is captured and the FSM returns to IDLE. A subsequent stop gives no `done`.
- **Reset and filter:**
  - `rst_n` low mid-TIMING → all outputs 0 with no pulses.
  - With `DECAY_MIN_FILTER_EN` and MIN_TICKS=2: a stop at 1 tick is ignored, a stop at 3 ticks is captured as 16'h0003.

Source files
------------

// File: rtl/decay_pkg.sv
// decay_pkg: shared types, constants and BCD helpers for the muon decay timer.
//   state_e     - FSM state type (IDLE, TIMING)
//   bcd_digit_t - one packed BCD digit
//   bcd_word_t  - four packed BCD digits, nibble [15:12] most significant
//   BCD_MAX     - largest representable 4-digit BCD value
package decay_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        TIMING = 1'b1
    } state_e;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [15:0] bcd_word_t;

    localparam bcd_word_t BCD_MAX = 16'h9999;

    // Add one to a 4-digit BCD word; each digit wraps 9 -> 0 and carries upward.
    function automatic bcd_word_t bcd_inc(input bcd_word_t val);
        bcd_word_t  res;
        bcd_digit_t dig;
        logic       carry;
        res   = val;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dig = val[i*4 +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = dig + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Elaboration-time conversion of a constant threshold; not used on any datapath.
    function automatic bcd_word_t const_to_bcd(input int unsigned val);
        bcd_word_t   res;
        int unsigned rem;
        res = '0;
        rem = (val > 9999) ? 9999 : val;
        for (int i = 0; i < 4; i++) begin
            res[i*4 +: 4] = 4'(rem % 10);
            rem           = rem / 10;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: 4-digit BCD up-counter.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears the count
//   clr    - synchronous clear (wins over inc)
//   inc    - advance the count by one BCD step
//   value  - current count, nibble [15:12] most significant
//   at_max - high while value is 9999
// The counter wraps from 9999 to 0000; callers that need saturation gate inc with at_max.
module bcd_counter4
    import decay_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      inc,
    output bcd_word_t value,
    output logic      at_max
);

    bcd_word_t value_q;
    bcd_word_t value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = bcd_inc(value_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign at_max = (value_q == BCD_MAX);

endmodule

// File: rtl/decay_timer.sv
// decay_timer: measures the interval between a start pulse (muon arrival) and a stop
// pulse (decay electron) in BCD ticks, and counts accepted decays.
//   Parameters:
//     TICK_DIV  - clock cycles per tick (>= 2)
//     MIN_TICKS - shortest accepted interval, only with DECAY_MIN_FILTER_EN defined
//   Ports:
//     clk         - system clock, rising edge
//     rst_n       - asynchronous active-low reset
//     start_pulse - one-cycle channel A event
//     stop_pulse  - one-cycle channel B event
//     digits_T    - BCD ticks of the last accepted interval
//     digits_N    - BCD count of accepted decays, saturating at 9999
//     busy        - high while timing
//     done        - one-cycle pulse when digits_T updates
//     timeout     - one-cycle pulse when a measurement overflows
// Build option: define DECAY_MIN_FILTER_EN to reject stops arriving before MIN_TICKS
// (afterpulse rejection); by default every stop while timing is accepted.
module decay_timer
    import decay_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned MIN_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_pulse,
    input  logic        stop_pulse,
    output logic [15:0] digits_T,
    output logic [15:0] digits_N,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    localparam int unsigned PreW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

    state_e          state_q, state_d;
    logic [PreW-1:0] pre_q, pre_d;
    bcd_word_t       digits_t_q, digits_t_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;

    logic      elapsed_clr;
    logic      elapsed_inc;
    bcd_word_t elapsed;
    logic      elapsed_at_max;

    logic      count_inc;
    bcd_word_t count;
    logic      count_at_max;

    logic      accept;
    logic      stop_ok;
    logic      tick_due;

    bcd_counter4 u_elapsed (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (elapsed_clr),
        .inc    (elapsed_inc),
        .value  (elapsed),
        .at_max (elapsed_at_max)
    );

    bcd_counter4 u_count (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (count_inc),
        .value  (count),
        .at_max (count_at_max)
    );

    assign tick_due = (pre_q == PreLast);

`ifdef DECAY_MIN_FILTER_EN
    localparam bcd_word_t MinBcd = const_to_bcd(MIN_TICKS);
    // BCD words order the same way as their decimal values, so a plain compare works.
    assign stop_ok = stop_pulse && (elapsed >= MinBcd);
`else
    assign stop_ok = stop_pulse;
`endif

    // Decay count holds at 9999; done still pulses for every accepted stop.
    assign count_inc = accept && !count_at_max;

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        digits_t_d  = digits_t_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        elapsed_clr = 1'b0;
        elapsed_inc = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    pre_d       = '0;
                    elapsed_clr = 1'b1;
                    state_d     = TIMING;
                end
            end
            TIMING: begin
                // Priority: stop, then retrigger, then overflow, then normal counting.
                if (stop_ok) begin
                    accept     = 1'b1;
                    digits_t_d = elapsed;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else if (start_pulse) begin
                    pre_d       = '0;
                    elapsed_clr = 1'b1;
                end else if (tick_due && elapsed_at_max) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (tick_due) begin
                    pre_d       = '0;
                    elapsed_inc = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            digits_t_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            digits_t_q <= digits_t_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign digits_T = digits_t_q;
    assign digits_N = count;
    assign busy     = (state_q == TIMING);
    assign done     = done_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_decay_timer.sv
// Bench for decay_timer: three instances (TICK_DIV = 100, 10, 2) share one stimulus
// stream and are compared every cycle against an interval-arithmetic reference model.
module tb_decay_timer;

    localparam int NDUT = 3;
    localparam int MIN  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_pulse = 1'b0;
    logic stop_pulse = 1'b0;

    logic [15:0] dig_t [NDUT];
    logic [15:0] dig_n [NDUT];
    logic        busy_o [NDUT];
    logic        done_o [NDUT];
    logic        tmo_o [NDUT];

    int td [NDUT] = '{100, 10, 2};

    // Reference model: measurement start cycle and decimal results.
    int cyc;
    int m_busy [NDUT];
    int m_st [NDUT];
    int m_t [NDUT];
    int m_n [NDUT];
    int m_done [NDUT];
    int m_to [NDUT];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decay_timer #(.TICK_DIV(100), .MIN_TICKS(MIN)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
        .digits_T(dig_t[0]), .digits_N(dig_n[0]), .busy(busy_o[0]), .done(done_o[0]),
        .timeout(tmo_o[0])
    );
    decay_timer #(.TICK_DIV(10), .MIN_TICKS(MIN)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
        .digits_T(dig_t[1]), .digits_N(dig_n[1]), .busy(busy_o[1]), .done(done_o[1]),
        .timeout(tmo_o[1])
    );
    decay_timer #(.TICK_DIV(2), .MIN_TICKS(MIN)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
        .digits_T(dig_t[2]), .digits_N(dig_n[2]), .busy(busy_o[2]), .done(done_o[2]),
        .timeout(tmo_o[2])
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16
               + (v % 10);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_busy[i] = 0; m_st[i] = 0; m_t[i] = 0; m_n[i] = 0; m_done[i] = 0; m_to[i] = 0;
        end
    endtask

    // One clock edge of the model: interval in ticks is floor((edges since start - 1)/TD).
    task automatic model_step(input logic s, input logic p);
        int k;
        int ticks;
        bit ok;
        cyc++;
        for (int i = 0; i < NDUT; i++) begin
            m_done[i] = 0;
            m_to[i]   = 0;
            if (m_busy[i] == 0) begin
                if (s) begin
                    m_busy[i] = 1;
                    m_st[i]   = cyc;
                end
            end else begin
                k     = cyc - m_st[i];
                ticks = (k - 1) / td[i];
                ok    = p;
`ifdef DECAY_MIN_FILTER_EN
                ok = p && (ticks >= MIN);
`endif
                if (ok) begin
                    m_t[i]    = ticks;
                    m_n[i]    = (m_n[i] < 9999) ? m_n[i] + 1 : 9999;
                    m_done[i] = 1;
                    m_busy[i] = 0;
                end else if (s) begin
                    m_st[i] = cyc;
                end else if (k >= 10000 * td[i]) begin
                    m_to[i]   = 1;
                    m_busy[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("d%0d.digits_T", i), int'(dig_t[i]), to_bcd(m_t[i]));
            check_eq($sformatf("d%0d.digits_N", i), int'(dig_n[i]), to_bcd(m_n[i]));
            check_eq($sformatf("d%0d.busy", i), int'(busy_o[i]), m_busy[i]);
            check_eq($sformatf("d%0d.done", i), int'(done_o[i]), m_done[i]);
            check_eq($sformatf("d%0d.timeout", i), int'(tmo_o[i]), m_to[i]);
        end
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, check at the next negedge.
    task automatic cycle(input logic s, input logic p);
        start_pulse = s;
        stop_pulse  = p;
        @(posedge clk);
        model_step(s, p);
        @(negedge clk);
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        int to_at;
        cyc = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Basic measurement: stop 250 cycles after start.
        busy_cnt = 0;
        cycle(1'b1, 1'b0);
        if (busy_o[0]) busy_cnt++;
        for (int i = 0; i < 249; i++) begin
            cycle(1'b0, 1'b0);
            if (busy_o[0]) busy_cnt++;
        end
        cycle(1'b0, 1'b1);
        check_eq("basic.T", int'(dig_t[0]), 16'h0002);
        check_eq("basic.N", int'(dig_n[0]), 16'h0001);
        check_eq("basic.done", int'(done_o[0]), 1);
        check_eq("basic.busy_cycles", busy_cnt, 250);
        idle(3);

        // Stop without start.
        apply_reset();
        cycle(1'b0, 1'b1);
        check_eq("nostart.done", int'(done_o[0]), 0);
        check_eq("nostart.T", int'(dig_t[1]), 16'h0000);
        idle(2);

        // Retrigger on the TICK_DIV=10 instance.
        cycle(1'b1, 1'b0);
        idle(499);
        cycle(1'b1, 1'b0);
        idle(1233);
        cycle(1'b0, 1'b1);
        check_eq("retrig.T", int'(dig_t[1]), 16'h0123);
        check_eq("retrig.N", int'(dig_n[1]), 16'h0001);

        // Simultaneous start and stop while timing, then a lone stop.
        cycle(1'b1, 1'b0);
        idle(50);
        cycle(1'b1, 1'b1);
        check_eq("simul.T", int'(dig_t[2]), 16'h0025);
        check_eq("simul.busy", int'(busy_o[2]), 0);
        cycle(1'b0, 1'b1);
        check_eq("simul.nodone", int'(done_o[2]), 0);

        // Overflow on the TICK_DIV=2 instance: timeout 20000 edges after start.
        to_at = -1;
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= 20005; i++) begin
            cycle(1'b0, 1'b0);
            if (tmo_o[2] && to_at < 0) to_at = i;
        end
        check_eq("ovf.edge", to_at, 20000);
        check_eq("ovf.T_kept", int'(dig_t[2]), 16'h0025);
        check_eq("ovf.busy", int'(busy_o[2]), 0);

        // Reset mid-measurement.
        cycle(1'b1, 1'b0);
        idle(30);
        apply_reset();
        check_eq("rst.N", int'(dig_n[1]), 16'h0000);
        idle(2);

`ifdef DECAY_MIN_FILTER_EN
        // Afterpulse rejection on the TICK_DIV=2 instance.
        cycle(1'b1, 1'b0);
        idle(2);
        cycle(1'b0, 1'b1);
        check_eq("filt.reject_done", int'(done_o[2]), 0);
        check_eq("filt.reject_busy", int'(busy_o[2]), 1);
        idle(3);
        cycle(1'b0, 1'b1);
        check_eq("filt.accept_T", int'(dig_t[2]), 16'h0003);
        idle(2);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                apply_reset();
            end else begin
                cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0));
            end
        end

        // Decay count saturation.
        apply_reset();
        for (int i = 0; i < 10001; i++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b1);
        end
`ifndef DECAY_MIN_FILTER_EN
        check_eq("sat.N", int'(dig_n[1]), 16'h9999);
        check_eq("sat.done", int'(done_o[1]), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
